i2c_master_sequencer: RTL

I2C_MASTER_SEQUENCER -- requirements
Module: i2c_master_sequencer

---
 rtl/i2c_pkg.sv | 36 +++
 rtl/i2c_master_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_pkg.sv
// Shared types for the I2C master sequencer: bus operation, byte-engine
// command set, transaction status and the sequencer state encoding.
package i2c_pkg;

    typedef enum logic {
        OP_WRITE = 1'b0,
        OP_READ  = 1'b1
    } i2c_op_t;

    typedef enum logic [2:0] {
        CMD_START    = 3'd0,
        CMD_STOP     = 3'd1,
        CMD_WRITE    = 3'd2,
        CMD_READ_ACK = 3'd3,
        CMD_READ_NAK = 3'd4
    } i2c_cmd_t;

    typedef enum logic [1:0] {
        STS_OK       = 2'd0,
        STS_NAK_ADDR = 2'd1,
        STS_NAK_DATA = 2'd2,
        STS_ARB_LOST = 2'd3
    } i2c_seq_status_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_ADDR  = 3'd2,
        S_WDATA = 3'd3,
        S_RDATA = 3'd4,
        S_RPUSH = 3'd5,
        S_STOP  = 3'd6,
        S_FIN   = 3'd7
    } seq_state_t;

endpackage

// File: rtl/i2c_master_sequencer.sv
// I2C master transaction sequencer. Turns one request (address, op, length)
// into a sequence of byte-engine commands, streams write bytes in and read
// bytes out, and reports a status with a one-cycle done pulse.
// Optional feature: define I2C_SEQ_REPEATED_START_EN to add req_chain_i,
// which lets a successful transaction skip STOP so the next one begins
// with a repeated start.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a request, req_ready_o high
// START  | issue CMD_START and wait for its completion
// ADDR   | issue CMD_WRITE of {addr,op}, decide on ACK/NAK and length
// WDATA  | accept a write byte, issue CMD_WRITE, wait for completion
// RDATA  | issue CMD_READ_ACK / CMD_READ_NAK (last byte), wait for data
// RPUSH  | present the read byte until the consumer takes it
// STOP   | issue CMD_STOP and wait for its completion
// FIN    | one-cycle done pulse, status_o updated, then back to IDLE
module i2c_master_sequencer
    import i2c_pkg::*;
#(
    parameter int I2C_ADDR_WIDTH = 7,
    parameter int I2C_DATA_WIDTH = 8,
    parameter int LEN_WIDTH      = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [I2C_ADDR_WIDTH-1:0] req_addr_i,
    input  i2c_op_t                   req_op_i,
    input  logic [LEN_WIDTH-1:0]      req_len_i,
`ifdef I2C_SEQ_REPEATED_START_EN
    input  logic                      req_chain_i,
`endif
    input  logic                      wdata_valid_i,
    output logic                      wdata_ready_o,
    input  logic [I2C_DATA_WIDTH-1:0] wdata_i,
    output logic                      rdata_valid_o,
    input  logic                      rdata_ready_i,
    output logic [I2C_DATA_WIDTH-1:0] rdata_o,
    output logic                      eng_cmd_valid_o,
    input  logic                      eng_cmd_ready_i,
    output i2c_cmd_t                  eng_cmd_o,
    output logic [I2C_DATA_WIDTH-1:0] eng_wdata_o,
    input  logic                      eng_done_i,
    input  logic                      eng_ack_i,
    input  logic                      eng_arb_lost_i,
    input  logic [I2C_DATA_WIDTH-1:0] eng_rdata_i,
    output logic                      busy_o,
    output logic                      done_o,
    output i2c_seq_status_t           status_o
);

    seq_state_t                  state_q,  state_d;
    logic [I2C_ADDR_WIDTH-1:0]   addr_q,   addr_d;
    i2c_op_t                     op_q,     op_d;
    logic [LEN_WIDTH-1:0]        cnt_q,    cnt_d;
    logic                        cmd_valid_q, cmd_valid_d;
    logic                        wait_q,   wait_d;
    i2c_cmd_t                    cmd_q,    cmd_d;
    logic [I2C_DATA_WIDTH-1:0]   ewdata_q, ewdata_d;
    logic [I2C_DATA_WIDTH-1:0]   rdata_q,  rdata_d;
    i2c_seq_status_t             result_q, result_d;
    i2c_seq_status_t             status_q, status_d;
`ifdef I2C_SEQ_REPEATED_START_EN
    logic                        chain_q,  chain_d;
`endif

    // A command slot is free when nothing is waiting to be accepted or completed.
    logic       slot_free;
    logic       done_seen;
    seq_state_t end_state;

    assign slot_free = !cmd_valid_q && !wait_q;
    assign done_seen = wait_q && eng_done_i;

    // State and datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            op_q        <= OP_WRITE;
            cnt_q       <= '0;
            cmd_valid_q <= 1'b0;
            wait_q      <= 1'b0;
            cmd_q       <= CMD_START;
            ewdata_q    <= '0;
            rdata_q     <= '0;
            result_q    <= STS_OK;
            status_q    <= STS_OK;
`ifdef I2C_SEQ_REPEATED_START_EN
            chain_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            cmd_valid_q <= cmd_valid_d;
            wait_q      <= wait_d;
            cmd_q       <= cmd_d;
            ewdata_q    <= ewdata_d;
            rdata_q     <= rdata_d;
            result_q    <= result_d;
            status_q    <= status_d;
`ifdef I2C_SEQ_REPEATED_START_EN
            chain_q     <= chain_d;
`endif
        end
    end

    // Next-state and command sequencing.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        cmd_valid_d = cmd_valid_q;
        wait_d      = wait_q;
        cmd_d       = cmd_q;
        ewdata_d    = ewdata_q;
        rdata_d     = rdata_q;
        result_d    = result_q;
        status_d    = status_q;
`ifdef I2C_SEQ_REPEATED_START_EN
        chain_d     = chain_q;
        end_state   = chain_q ? S_FIN : S_STOP;
`else
        end_state   = S_STOP;
`endif

        if (cmd_valid_q && eng_cmd_ready_i) begin
            cmd_valid_d = 1'b0;
            wait_d      = 1'b1;
        end
        if (done_seen) begin
            wait_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    addr_d   = req_addr_i;
                    op_d     = req_op_i;
                    cnt_d    = req_len_i;
                    result_d = STS_OK;
`ifdef I2C_SEQ_REPEATED_START_EN
                    chain_d  = req_chain_i;
`endif
                    state_d  = S_START;
                end
            end
            S_START: begin
                if (slot_free) begin
                    cmd_valid_d = 1'b1;
                    cmd_d       = CMD_START;
                end else if (done_seen) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (slot_free) begin
                    cmd_valid_d = 1'b1;
                    cmd_d       = CMD_WRITE;
                    ewdata_d    = I2C_DATA_WIDTH'({addr_q, op_q});
                end else if (done_seen) begin
                    if (!eng_ack_i) begin
                        result_d = STS_NAK_ADDR;
                        state_d  = S_STOP;
                    end else if (cnt_q == '0) begin
                        state_d = end_state;
                    end else begin
                        state_d = (op_q == OP_READ) ? S_RDATA : S_WDATA;
                    end
                end
            end
            S_WDATA: begin
                if (slot_free) begin
                    if (wdata_valid_i) begin
                        cmd_valid_d = 1'b1;
                        cmd_d       = CMD_WRITE;
                        ewdata_d    = wdata_i;
                    end
                end else if (done_seen) begin
                    cnt_d = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
                    if (!eng_ack_i) begin
                        result_d = STS_NAK_DATA;
                        state_d  = S_STOP;
                    end else if (cnt_q == LEN_WIDTH'(1)) begin
                        state_d = end_state;
                    end
                end
            end
            S_RDATA: begin
                if (slot_free) begin
                    cmd_valid_d = 1'b1;
                    cmd_d       = (cnt_q == LEN_WIDTH'(1)) ? CMD_READ_NAK : CMD_READ_ACK;
                end else if (done_seen) begin
                    cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
                    rdata_d = eng_rdata_i;
                    state_d = S_RPUSH;
                end
            end
            S_RPUSH: begin
                if (rdata_ready_i) begin
                    state_d = (cnt_q == '0) ? end_state : S_RDATA;
                end
            end
            S_STOP: begin
                if (slot_free) begin
                    cmd_valid_d = 1'b1;
                    cmd_d       = CMD_STOP;
                end else if (done_seen) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Lost arbitration releases the bus to the winner, so no STOP is sent.
        if (done_seen && eng_arb_lost_i) begin
            result_d = STS_ARB_LOST;
            state_d  = S_FIN;
        end

        if (state_d == S_FIN && state_q != S_FIN) begin
            status_d = result_d;
        end
    end

    // Outputs decoded from state and registers.
    always_comb begin
        req_ready_o     = (state_q == S_IDLE);
        busy_o          = (state_q != S_IDLE);
        done_o          = (state_q == S_FIN);
        wdata_ready_o   = (state_q == S_WDATA) && slot_free;
        rdata_valid_o   = (state_q == S_RPUSH);
        rdata_o         = rdata_q;
        eng_cmd_valid_o = cmd_valid_q;
        eng_cmd_o       = cmd_q;
        eng_wdata_o     = ewdata_q;
        status_o        = status_q;
    end

endmodule
